// File: rtl/ffm_uart_pkg.sv
// Shared types and constants for the FFM sensor poll UART receiver.
// Holds controller/receiver state encodings, error codes and default timing.
package ffm_uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_FRAME_LEN    = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } ctl_state_t;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RESP_TO = 2'd1;
  localparam logic [1:0] ERR_BYTE_TO = 2'd2;
  localparam logic [1:0] ERR_FRAME   = 2'd3;

endpackage

// File: rtl/ffm_poll_uart_rx_if.sv
// Byte-write port into the frame buffer: one strobe per received byte.
interface ffm_poll_uart_rx_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/ffm_uart_rx_byte.sv
// 8N1 byte receiver: synchronizes rx, hunts for a start edge while armed,
// samples mid-bit and flags each byte as accepted or stop-bit errored.
module ffm_uart_rx_byte
  import ffm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk80,
  input  logic       rst,
  input  logic       rx,
  input  logic       arm,
  output logic       hunting,
  output logic       byte_valid,
  output logic       stop_err,
  output logic [7:0] rx_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_t      state_reg, state_next;
  logic [2:0]     sync_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2:0]     bit_idx_reg;
  logic [7:0]     shift_reg;
  logic           rx_s, fall, mid_hit, bit_hit;

  // bits [1:0] form the synchronizer, bit 2 is the previous rx_s for edge detection
  always_ff @(posedge clk80) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= {sync_reg[1:0], rx};
  end

  always_comb begin
    rx_s    = sync_reg[1];
    fall    = sync_reg[2] & ~sync_reg[1];
    mid_hit = (cnt_reg == MID_CNT);
    bit_hit = (cnt_reg == LAST_CNT);
  end

  always_ff @(posedge clk80) begin
    if (rst) state_reg <= RX_HUNT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!arm) begin
      state_next = RX_HUNT;
    end else begin
      case (state_reg)
        RX_HUNT:  if (fall) state_next = RX_START;
        RX_START: if (mid_hit) state_next = rx_s ? RX_HUNT : RX_DATA;
        RX_DATA:  if (bit_hit && bit_idx_reg == 3'd7) state_next = RX_STOP;
        RX_STOP:  if (bit_hit) state_next = RX_HUNT;
        default:  state_next = RX_HUNT;
      endcase
    end
  end

  always_comb begin
    hunting    = arm && (state_reg == RX_HUNT);
    byte_valid = arm && (state_reg == RX_STOP) && bit_hit && rx_s;
    stop_err   = arm && (state_reg == RX_STOP) && bit_hit && !rx_s;
    rx_byte    = shift_reg;
  end

  always_ff @(posedge clk80) begin
    if (rst) begin
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      case (state_reg)
        RX_HUNT: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
        end
        RX_START: cnt_reg <= mid_hit ? '0 : cnt_reg + 1'b1;
        RX_DATA: begin
          if (bit_hit) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: cnt_reg <= bit_hit ? '0 : cnt_reg + 1'b1;
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: rtl/ffm_poll_uart_rx.sv
// Poll initiator and frame receiver for one FFM UART sensor channel:
// request pulse, reply/inter-byte timeouts, byte indexing and sync check.
module ffm_poll_uart_rx
  import ffm_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int         FRAME_LEN    = DEF_FRAME_LEN,
  parameter logic [7:0] SYNC_BYTE    = 8'h55,
  parameter int         REQ_WIDTH    = 32,
  parameter int         RESP_TIMEOUT = 4096,
  parameter int         BYTE_TIMEOUT = 64
) (
  input  logic               clk80,
  input  logic               rst,
  input  logic               poll,
  input  logic               rx,
  output logic               req,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_err,
  output logic [1:0]         err_code,
  ffm_poll_uart_rx_if.master wr
);

  localparam int RCW = $clog2(REQ_WIDTH + 1);
  localparam int TW  = $clog2(RESP_TIMEOUT + BYTE_TIMEOUT + 1);
  localparam logic [RCW-1:0] REQ_LAST  = RCW'(REQ_WIDTH - 1);
  localparam logic [TW-1:0]  RESP_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0]  BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [3:0]     LAST_IDX  = 4'(FRAME_LEN - 1);

  ctl_state_t     state_reg, state_next;
  logic [RCW-1:0] req_cnt_reg;
  logic [TW-1:0]  to_cnt_reg;
  logic [3:0]     idx_reg;

  logic       req_reg, req_next;
  logic       busy_reg, busy_next;
  logic       wr_en_reg, wr_en_next;
  logic [3:0] wr_addr_reg, wr_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic       frame_done_reg, frame_done_next;
  logic       frame_err_reg, frame_err_next;
  logic [1:0] err_code_reg, err_code_next;

  logic       hunting, byte_valid, stop_err;
  logic [7:0] rx_byte;
  logic       arm, accept_poll, req_end, to_hit, sync_bad, byte_ok, abort;

  ffm_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk80     (clk80),
    .rst       (rst),
    .rx        (rx),
    .arm       (arm),
    .hunting   (hunting),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .rx_byte   (rx_byte)
  );

  // A poll landing on the cycle a done/err pulse is out is dropped, keeping them apart
  always_comb begin
    arm         = (state_reg == ST_WAIT);
    accept_poll = (state_reg == ST_IDLE) && poll && !frame_done_reg && !frame_err_reg;
    req_end     = (state_reg == ST_REQ) && (req_cnt_reg == REQ_LAST);
    to_hit      = arm && hunting &&
                  (to_cnt_reg == ((idx_reg == 4'd0) ? RESP_LAST : BYTE_LAST));
    sync_bad    = arm && byte_valid && (idx_reg == 4'd0) && (rx_byte != SYNC_BYTE);
    byte_ok     = arm && byte_valid && !sync_bad;
    abort       = to_hit || sync_bad || (arm && stop_err);
  end

  always_ff @(posedge clk80) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept_poll) state_next = ST_REQ;
      ST_REQ:  if (req_end) state_next = ST_WAIT;
      ST_WAIT: begin
        if (abort)                                 state_next = ST_IDLE;
        else if (byte_ok && (idx_reg == LAST_IDX)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_next        = (state_next == ST_REQ);
    busy_next       = (state_next != ST_IDLE);
    wr_en_next      = byte_ok;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = (state_reg == ST_DONE);
    frame_err_next  = abort;
    err_code_next   = err_code_reg;
    if (state_next == ST_IDLE) wr_addr_next = 4'd0;
    if (byte_ok) begin
      wr_addr_next = idx_reg;
      wr_data_next = rx_byte;
    end
    if (abort) begin
      if (to_hit) err_code_next = (idx_reg == 4'd0) ? ERR_RESP_TO : ERR_BYTE_TO;
      else        err_code_next = ERR_FRAME;
    end
  end

  // The stop-sample cycle of an accepted byte counts as the first idle cycle
  always_ff @(posedge clk80) begin
    if (rst) begin
      req_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      idx_reg        <= '0;
      req_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      req_cnt_reg <= (state_reg == ST_REQ) ? req_cnt_reg + 1'b1 : '0;
      if (state_reg != ST_WAIT) to_cnt_reg <= '0;
      else if (byte_ok)         to_cnt_reg <= TW'(1);
      else if (hunting)         to_cnt_reg <= to_cnt_reg + 1'b1;
      if (state_reg == ST_IDLE) idx_reg <= '0;
      else if (byte_ok)         idx_reg <= idx_reg + 4'd1;
      req_reg        <= req_next;
      busy_reg       <= busy_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      err_code_reg   <= err_code_next;
    end
  end

  assign req        = req_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign wr.wr_en   = wr_en_reg;
  assign wr.wr_addr = wr_addr_reg;
  assign wr.wr_data = wr_data_reg;

endmodule

// File: doc/ffm_poll_uart_rx.md
Name: ffm_poll_uart_rx

Overview:
- Initiator/receiver for the sensor poll link used on the FFM UART channels (UART1/3/4/5/7).
- On each poll trigger, it drives the request line (the `_dRX` output) high for a fixed pulse.
- It then receives a fixed-length reply of 8N1 bytes, LSB first, on the matching RX line.
- Each received byte is written to a frame buffer through a byte-write interface, and the frame is reported as done or errored.
- One instance per channel, inside TheFFM, running on clk80.

Parameters:
- CLKS_PER_BIT, 16, clk80 cycles per UART bit (80 MHz / 5 Mbaud).
- FRAME_LEN, 15, bytes per reply frame.
- SYNC_BYTE, 8'h55, required value of byte 0.
- REQ_WIDTH, 32, clk80 cycles the request line is held high.
- RESP_TIMEOUT, 4096, maximum cycles from request falling edge to the first start bit.
- BYTE_TIMEOUT, 64, maximum idle cycles between a stop-bit sample and the next start bit.

Ports:
- clk80  in  1  system clock, 80 MHz.
- rst  in  1  synchronous reset, active-high.
- poll  in  1  single-cycle poll trigger; ignored unless the block is idle.
- rx  in  1  serial reply line, asynchronous; idles high.
- req  out  1  request pulse to the sensor (the `_dRX` line).
- wr_en  out  1  one-cycle strobe: wr_data is valid at wr_addr.
- wr_addr  out  4  byte index within the frame, 0..FRAME_LEN-1.
- wr_data  out  8  received byte.
- busy  out  1  high from poll acceptance until frame_done or frame_err.
- frame_done  out  1  one-cycle pulse: FRAME_LEN bytes received, sync byte matched.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  valid with frame_err. 1 = response timeout, 2 = inter-byte timeout, 3 = stop-bit error or sync mismatch. Holds its value until the next error.

Behaviour:
- Reset values:
  - req=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, err_code=0.
  - State machine in IDLE; synchronizer flops set to 1.
  - Reset mid-frame aborts immediately; no frame_err or frame_done is emitted.
- Input conditioning: rx passes through a 2-flop synchronizer (rx_s). All edge detection and sampling use rx_s.
- IDLE:
  - On poll=1, go to REQ. busy rises on the next cycle.
  - req rises in the same registered update and stays high for exactly REQ_WIDTH cycles.
- REQ: when the pulse ends, req=0, the timeout counter is cleared, and the state goes to WAIT_START with the RESP_TIMEOUT limit.
- WAIT_START:
  - A 1->0 transition on rx_s moves to START with the bit counter cleared.
  - If the timeout counter reaches its limit (RESP_TIMEOUT for byte 0, BYTE_TIMEOUT otherwise), pulse frame_err with the matching err_code and go to IDLE.
- START:
  - At count CLKS_PER_BIT/2-1, sample rx_s.
  - If it is 1, treat it as a glitch and return to WAIT_START. The timeout counter is not reset.
  - If it is 0, go to DATA.
- DATA:
  - Sample every CLKS_PER_BIT cycles and shift right into the byte (first sample becomes bit 0).
  - After the 8th sample, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - If the sample is 0, it is a stop-bit error.
  - If the sample is 1, byte accepted. wr_en pulses next cycle with wr_data, and wr_addr = byte index.
  - If byte 0 is not SYNC_BYTE, abort with err_code=3. No wr_en is issued for the bad byte.
  - After an accepted byte, the index increments. When index == FRAME_LEN-1 was just written, pulse frame_done and go to IDLE; otherwise go to WAIT_START with the BYTE_TIMEOUT limit.
- Back-to-back bytes: a start bit that begins immediately after the stop-bit sample point must be caught. Edge detection in WAIT_START is active from the first cycle after the stop sample.
- Start bits shorter than one bit time, but at least CLKS_PER_BIT/2+2 cycles, must be received correctly.
- Poll asserted while busy: ignored, with no queuing.
- frame_done and frame_err are mutually exclusive and never assert in the same cycle as a poll acceptance.
- wr_addr wraps nowhere: it is held at 0 in IDLE and never exceeds FRAME_LEN-1.

Decomposition:
- Shared package ffm_uart_pkg holds:
  - the state enum;
  - the err_code constants (ERR_NONE, ERR_RESP_TO, ERR_BYTE_TO, ERR_FRAME);
  - the defaults for CLKS_PER_BIT and FRAME_LEN.
- One natural sub-module: ffm_uart_rx_byte, which contains the synchronizer, start/data/stop sampling, and emits byte_valid, byte, and stop_err.
- The top level keeps the request pulse, timeouts, byte indexing and sync check.

Test Plan:
- Nominal frame: poll; sensor model waits for req high then low, and sends 55 91 92 93 94 55 95 96 97 98 55 99 9A 9B 9C at 200 ns/bit.
  - Expect req high for 32 cycles.
  - Expect 15 wr_en pulses, addr 0..14, data matching.
  - Expect one frame_done; busy falls.
- No reply: poll with rx held at 1.
  - Expect frame_err with err_code=1 exactly RESP_TIMEOUT cycles after req falls.
  - Expect no wr_en.
- Bad sync and bad stop, run separately:
  - First byte 0x54 -> frame_err with err_code=3, no wr_en.
  - Byte 3 with stop bit 0 -> 3 wr_en pulses (addr 0..2), then frame_err with err_code=3.
- Truncated frame: reply stops after 7 bytes.
  - Expect wr_addr 0..6 written.
  - Expect frame_err with err_code=2 BYTE_TIMEOUT cycles after the 7th stop sample.
- Glitch and ignored poll:
  - A 3-cycle low pulse on rx before byte 0 produces no byte and no error; the normal frame that follows completes.
  - A poll asserted mid-frame produces no second req pulse.
- Reset mid-frame: assert rst during byte 5.
  - All outputs go to their reset values the next cycle, with no frame_done or frame_err.
  - A following poll completes a full frame.
